// File: rtl/mem_stage.sv
// MEM pipeline stage: 256x16 data memory with synchronous read, branch resolution,
// and the MEM/WB pipeline register with alignment/range fault detection.
module mem_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        validIn,
  input  logic        stall,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [15:0] outputBranch,
  input  logic [15:0] outputALU,
  input  logic [15:0] storeData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic [2:0]  writeReg,
  output logic        PCSrc,
  output logic [15:0] branchTarget,
  output logic [15:0] writeDataWB,
  output logic [2:0]  writeRegWB,
  output logic        RegWriteWB,
  output logic        validWB,
  output logic        memFault
);

  logic [15:0] mem [0:255];
  logic [7:0]  index;
  logic        legal;
  logic        access;
  logic        do_write;

  assign index    = outputALU[8:1];
  // Upper bits must be zero so addresses >= 0x0200 fault instead of aliasing.
  assign legal    = ~outputALU[0] & (outputALU[15:9] == 7'd0);
  assign access   = validIn & (MemRead | MemWrite);
  assign do_write = validIn & MemWrite & ~stall & legal;

  assign PCSrc        = Branch & Zero & validIn;
  assign branchTarget = outputBranch;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    end else if (do_write) begin
      mem[index] <= storeData;
    end
  end

  // A load returns the pre-edge contents, so data written one edge earlier is visible.
  always_ff @(posedge clock) begin
    if (reset) begin
      writeDataWB <= 16'h0000;
      writeRegWB  <= 3'd0;
      RegWriteWB  <= 1'b0;
      validWB     <= 1'b0;
      memFault    <= 1'b0;
    end else if (!stall) begin
      if (MemtoReg) writeDataWB <= legal ? mem[index] : 16'h0000;
      else          writeDataWB <= outputALU;
      writeRegWB <= writeReg;
      RegWriteWB <= RegWrite & validIn & ~(MemtoReg & ~legal);
      validWB    <= validIn;
      memFault   <= access & ~legal;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset, validIn, stall, Branch, Zero;
  logic [15:0] outputBranch, outputALU, storeData;
  logic        MemRead, MemWrite, MemtoReg, RegWrite;
  logic [2:0]  writeReg;
  logic        PCSrc;
  logic [15:0] branchTarget, writeDataWB;
  logic [2:0]  writeRegWB;
  logic        RegWriteWB, validWB, memFault;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_mem [256];
  logic [15:0] m_wd;
  logic [2:0]  m_wr;
  logic        m_rw, m_v, m_f;

  mem_stage dut (
    .clock(clock), .reset(reset), .validIn(validIn), .stall(stall),
    .Branch(Branch), .Zero(Zero), .outputBranch(outputBranch),
    .outputALU(outputALU), .storeData(storeData), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .writeReg(writeReg), .PCSrc(PCSrc), .branchTarget(branchTarget),
    .writeDataWB(writeDataWB), .writeRegWB(writeRegWB),
    .RegWriteWB(RegWriteWB), .validWB(validWB), .memFault(memFault)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    reset = 0; validIn = 0; stall = 0; Branch = 0; Zero = 0;
    outputBranch = 0; outputALU = 0; storeData = 0;
    MemRead = 0; MemWrite = 0; MemtoReg = 0; RegWrite = 0; writeReg = 0;
  endtask

  // Reference behaviour at one rising edge, from the stage's rules.
  task automatic model_edge();
    int  addr;
    bit  ok;
    logic [15:0] rdata;
    addr = int'(outputALU);
    ok = (addr % 2 == 0) && (addr < 512);
    if (reset) begin
      foreach (m_mem[i]) m_mem[i] = 16'h0000;
      m_wd = 0; m_wr = 0; m_rw = 0; m_v = 0; m_f = 0;
    end else if (!stall) begin
      rdata = ok ? m_mem[addr / 2] : 16'h0000;
      m_wd = MemtoReg ? rdata : outputALU;
      m_wr = writeReg;
      m_v  = validIn;
      m_rw = RegWrite && validIn && !(MemtoReg && !ok);
      m_f  = validIn && (MemRead || MemWrite) && !ok;
      if (validIn && MemWrite && ok) m_mem[addr / 2] = storeData;
    end
  endtask

  task automatic step();
    #1;
    chk("pcsrc", 32'(PCSrc), 32'(Branch && Zero && validIn));
    chk("btarget", 32'(branchTarget), 32'(outputBranch));
    model_edge();
    @(posedge clock);
    #1;
    chk("wdata", 32'(writeDataWB), 32'(m_wd));
    chk("wreg", 32'(writeRegWB), 32'(m_wr));
    chk("regwr", 32'(RegWriteWB), 32'(m_rw));
    chk("valid", 32'(validWB), 32'(m_v));
    chk("fault", 32'(memFault), 32'(m_f));
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    idle(); validIn = 1; MemWrite = 1; outputALU = a; storeData = d;
  endtask

  task automatic load(input logic [15:0] a, input logic [2:0] r);
    idle(); validIn = 1; MemRead = 1; MemtoReg = 1; RegWrite = 1; outputALU = a; writeReg = r;
  endtask

  initial begin
    logic [15:0] held;
    foreach (m_mem[i]) m_mem[i] = 16'hxxxx;
    idle(); reset = 1;
    step(); step();
    chk("reset_wdata", 32'(writeDataWB), 32'h0);
    chk("reset_valid", 32'(validWB), 32'h0);

    // store then load
    store(16'h0010, 16'hBEEF); step();
    load(16'h0010, 3'd3); step();
    chk("ld_beef", 32'(writeDataWB), 32'hBEEF);
    chk("ld_reg3", 32'(writeRegWB), 32'd3);
    chk("ld_rw", 32'(RegWriteWB), 32'd1);

    // pass-through and branch
    idle(); validIn = 1; RegWrite = 1; outputALU = 16'h1234; step();
    chk("alu_pass", 32'(writeDataWB), 32'h1234);
    idle(); validIn = 1; Branch = 1; Zero = 1; outputBranch = 16'h0040;
    #1; chk("br_taken", 32'(PCSrc), 32'd1); chk("br_tgt", 32'(branchTarget), 32'h0040);
    step();
    Zero = 0; #1; chk("br_not", 32'(PCSrc), 32'd0);
    step();

    // faults
    load(16'h0011, 3'd1); step();
    chk("mis_fault", 32'(memFault), 32'd1);
    chk("mis_rw", 32'(RegWriteWB), 32'd0);
    chk("mis_data", 32'(writeDataWB), 32'h0);
    store(16'h0400, 16'h7777); step();
    chk("oor_fault", 32'(memFault), 32'd1);
    load(16'h0000, 3'd2); step();
    chk("no_alias", 32'(writeDataWB), 32'h0);

    // stall
    store(16'h0020, 16'h1111); step();
    held = writeDataWB;
    store(16'h0020, 16'hAAAA); stall = 1; step(); step();
    chk("stall_hold", 32'(writeDataWB), 32'(held));
    load(16'h0020, 3'd4); step();
    chk("stall_nowr", 32'(writeDataWB), 32'h1111);

    // bubble
    store(16'h0010, 16'h9999); validIn = 0; Branch = 1; Zero = 1; step();
    chk("bub_valid", 32'(validWB), 32'd0);
    load(16'h0010, 3'd5); step();
    chk("bub_nowr", 32'(writeDataWB), 32'hBEEF);

    // read-modify in same cycle: both read and write treated as write
    idle(); validIn = 1; MemRead = 1; MemWrite = 1; outputALU = 16'h0030; storeData = 16'h4242; step();
    chk("rw_pass", 32'(writeDataWB), 32'h0030);

    // reset clears memory
    store(16'h0002, 16'h5555); step();
    idle(); reset = 1; validIn = 1; MemWrite = 1; outputALU = 16'h0004; storeData = 16'h6666; step();
    chk("rst_out", 32'({writeDataWB, writeRegWB, RegWriteWB, validWB, memFault}), 32'h0);
    load(16'h0002, 3'd6); step();
    chk("rst_clear", 32'(writeDataWB), 32'h0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      reset    = ($urandom_range(0, 49) == 0);
      validIn  = ($urandom_range(0, 9) != 0);
      stall    = ($urandom_range(0, 7) == 0);
      Branch   = $urandom_range(0, 1);
      Zero     = $urandom_range(0, 1);
      outputBranch = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       outputALU = 16'($urandom);
        1:       outputALU = 16'($urandom_range(0, 31) * 2 + 1);
        2:       outputALU = 16'h0200 + 16'($urandom_range(0, 15) * 2);
        default: outputALU = 16'($urandom_range(0, 31) * 2);
      endcase
      storeData = 16'($urandom);
      MemRead   = $urandom_range(0, 1);
      MemWrite  = $urandom_range(0, 1);
      MemtoReg  = $urandom_range(0, 1);
      RegWrite  = $urandom_range(0, 1);
      writeReg  = 3'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
